sd_req_arbiter: RTL

- Shares the single SD sector channel of user_io between two requesters: 0 = hard-disk image, 1 = floppy/secondary image.
- The channel is the sd_lba/sd_rd/sd_wr/sd_ack handshake plus the 512-byte sector buffer port.
- Grants round-robin, holds the grant for one whole sector transfer, routes buffer strobes and data to the owner only, and reports completion per requester.
- Sits between the per-drive emulation logic and user_io, in the clk_sys domain.

---
 rtl/sd_req_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter sharing the user_io SD sector channel between two requesters
// (0 = hard-disk image, 1 = floppy image). Optional REQ timeout: define SD_ARB_TIMEOUT_EN.
module sd_req_arbiter #(
    parameter int unsigned LBA_W   = 32,
    parameter logic [23:0] TIMEOUT = 24'd2500000
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic [1:0]       rq_rd,
    input  logic [1:0]       rq_wr,
    input  logic [LBA_W-1:0] rq_lba0,
    input  logic [LBA_W-1:0] rq_lba1,
    input  logic [7:0]       rq_din0,
    input  logic [7:0]       rq_din1,
    output logic [1:0]       rq_busy,
    output logic [1:0]       rq_done,
    output logic [1:0]       rq_err,
    output logic [1:0]       rq_buff_wr,
    output logic [LBA_W-1:0] sd_lba,
    output logic             sd_rd,
    output logic             sd_wr,
    input  logic             sd_ack,
    input  logic             sd_buff_wr,
    output logic [7:0]       sd_buff_din
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             dir_wr_q, dir_wr_d;
    logic             last_q, last_d;
    logic [LBA_W-1:0] lba_q, lba_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic [1:0]       busy_q, busy_d;
    logic [1:0]       done_q, done_d;
    logic [1:0]       err_q, err_d;

    logic [1:0]       pend;
    logic             pick;
    logic [1:0]       owner_mask;
    logic             timeout_hit;

    assign pend       = rq_rd | rq_wr;
    // The requester that did not win last time gets priority if it is pending.
    assign pick       = pend[~last_q] ? ~last_q : last_q;
    assign owner_mask = owner_q ? 2'b10 : 2'b01;

`ifdef SD_ARB_TIMEOUT_EN
    logic [23:0] cnt_q, cnt_d;

    // Counts REQ cycles; held at zero outside REQ so every REQ entry starts fresh.
    always_comb begin
        cnt_d = '0;
        if (state_q == REQ) begin
            cnt_d = cnt_q + 24'd1;
        end
    end

    assign timeout_hit = (state_q == REQ) && (cnt_d == TIMEOUT);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        dir_wr_d = dir_wr_q;
        last_d   = last_q;
        lba_d    = lba_q;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        busy_d   = busy_q;
        done_d   = 2'b00;
        err_d    = 2'b00;

        case (state_q)
            IDLE: begin
                if (|pend) begin
                    owner_d  = pick;
                    last_d   = pick;
                    // Read wins when a requester raises both strobes.
                    dir_wr_d = ~rq_rd[pick];
                    lba_d    = pick ? rq_lba1 : rq_lba0;
                    busy_d   = pick ? 2'b10 : 2'b01;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (sd_ack) begin
                    state_d = XFER;
                end else if (timeout_hit) begin
                    err_d   = owner_mask;
                    busy_d  = 2'b00;
                    state_d = IDLE;
                end else begin
                    rd_d = ~dir_wr_q;
                    wr_d = dir_wr_q;
                end
            end
            XFER: begin
                if (!sd_ack) begin
                    done_d  = owner_mask;
                    busy_d  = 2'b00;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            dir_wr_q <= 1'b0;
            last_q   <= 1'b1;
            lba_q    <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            busy_q   <= 2'b00;
            done_q   <= 2'b00;
            err_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            dir_wr_q <= dir_wr_d;
            last_q   <= last_d;
            lba_q    <= lba_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Buffer strobes and write data reach only the current owner.
    always_comb begin
        rq_buff_wr = 2'b00;
        if (state_q == XFER) begin
            rq_buff_wr = {owner_q & sd_buff_wr, ~owner_q & sd_buff_wr};
        end
    end

    always_comb begin
        sd_buff_din = 8'h00;
        if (state_q != IDLE) begin
            sd_buff_din = owner_q ? rq_din1 : rq_din0;
        end
    end

    assign rq_busy = busy_q;
    assign rq_done = done_q;
    assign rq_err  = err_q;
    assign sd_lba  = lba_q;
    assign sd_rd   = rd_q;
    assign sd_wr   = wr_q;

endmodule
